warp_barrier_unit: RTL and testbench

Scheduler-side responder for the barrier portion of the warp-control channel. It consumes barrier commands issued by the warp-control execution path and tracks per-barrier arrival counts, waiting-warp masks and generation tokens. It returns the current generation token for asynchronous-barrier lookups and drives the scheduler's barrier stall mask and one-cycle release pulses.

---
 rtl/warp_barrier_unit_pkg.sv | 19 +
 rtl/warp_barrier_unit_slot.sv | 101 ++++++++++
 rtl/warp_barrier_unit.sv | 90 +++++++++
 tb/tb_warp_barrier_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/warp_barrier_unit_pkg.sv
// Shared barrier types and width helpers for the warp barrier unit.
package VX_gpu_pkg;

  typedef enum logic [1:0] {
    BAR_SYNC   = 2'd0,
    BAR_ARRIVE = 2'd1,
    BAR_WAIT   = 2'd2
  } bar_op_t;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_WARPS_DEF    = 4;
  localparam int NUM_BARRIERS_DEF = 4;
  localparam int NW_WIDTH         = width_of(NUM_WARPS_DEF);
  localparam int NB_WIDTH         = width_of(NUM_BARRIERS_DEF);

endpackage

// File: rtl/warp_barrier_unit_slot.sv
// One barrier slot: arrival count, waiting masks, generation and completion detect.
// BARRIER_ASYNC_EN enables BAR_ARRIVE/BAR_WAIT and the generation token.
module warp_barrier_slot
  import VX_gpu_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int XLEN      = 32,
  parameter int NWW       = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cmd_i,
  input  bar_op_t              op_i,
  input  logic [NWW-1:0]       wid_i,
  input  logic [NWW-1:0]       size_m1_i,
  input  logic [XLEN-1:0]      token_i,
  output logic [XLEN-1:0]      gen_o,
  output logic                 complete_o,
  output logic [NUM_WARPS-1:0] release_mask_o,
  output logic [NUM_WARPS-1:0] stall_set_o
);

  logic [NWW-1:0]       count_q, count_d;
  logic [NUM_WARPS-1:0] sync_mask_q, sync_mask_d;
  logic [NUM_WARPS-1:0] wid_oh, waiters;
  logic                 is_sync, is_wait, wait_hit, arrival;

  assign wid_oh     = NUM_WARPS'(1) << wid_i;
  assign arrival    = cmd_i & ~is_wait;
  assign complete_o = arrival & (count_q == size_m1_i);

`ifdef BARRIER_ASYNC_EN
  logic [NUM_WARPS-1:0] wait_mask_q, wait_mask_d;
  logic [XLEN-1:0]      gen_q, gen_d;

  assign is_sync  = (op_i == BAR_SYNC);
  assign is_wait  = (op_i == BAR_WAIT);
  // A stale token means the generation already completed: nothing to wait for.
  assign wait_hit = cmd_i & is_wait & (token_i == gen_q);
  assign waiters  = wait_mask_q;
  assign gen_o    = gen_q;

  always_comb begin
    wait_mask_d = wait_mask_q;
    gen_d       = gen_q;
    if (complete_o) begin
      wait_mask_d = '0;
      gen_d       = gen_q + 1'b1;
    end else if (wait_hit) begin
      wait_mask_d = wait_mask_q | wid_oh;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_mask_q <= '0;
      gen_q       <= '0;
    end else begin
      wait_mask_q <= wait_mask_d;
      gen_q       <= gen_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{op_i, token_i};
  assign is_sync    = 1'b1;
  assign is_wait    = 1'b0;
  assign wait_hit   = 1'b0;
  assign waiters    = '0;
  assign gen_o      = '0;
`endif

  always_comb begin
    count_d        = count_q;
    sync_mask_d    = sync_mask_q;
    release_mask_o = '0;
    stall_set_o    = wait_hit ? wid_oh : '0;
    if (complete_o) begin
      count_d        = '0;
      sync_mask_d    = '0;
      release_mask_o = sync_mask_q | waiters | (is_sync ? wid_oh : '0);
    end else if (arrival) begin
      count_d = count_q + 1'b1;
      if (is_sync) begin
        sync_mask_d = sync_mask_q | wid_oh;
        stall_set_o = wid_oh;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q     <= '0;
      sync_mask_q <= '0;
    end else begin
      count_q     <= count_d;
      sync_mask_q <= sync_mask_d;
    end
  end

endmodule

// File: rtl/warp_barrier_unit.sv
// Barrier responder: decodes warp-control barrier commands into per-slot state and
// merges slot stall/release results. BARRIER_ASYNC_EN enables async barrier ops.
module warp_barrier_unit
  import VX_gpu_pkg::*;
#(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int XLEN         = 32,
  localparam int NWW         = width_of(NUM_WARPS),
  localparam int NBW         = width_of(NUM_BARRIERS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 ctl_valid_i,
  input  logic [NWW-1:0]       ctl_wid_i,
  input  logic                 bar_valid_i,
  input  bar_op_t              bar_op_i,
  input  logic [NBW-1:0]       bar_id_i,
  input  logic [NWW-1:0]       bar_size_m1_i,
  input  logic [XLEN-1:0]      bar_token_i,
  input  logic [NBW-1:0]       barrier_id_rd_i,
  output logic [XLEN-1:0]      arrive_token_o,
  output logic [NUM_WARPS-1:0] stalled_warps_o,
  output logic                 release_valid_o,
  output logic [NUM_WARPS-1:0] release_mask_o
);

  logic [NUM_WARPS-1:0] stalled_q, stalled_d;
  logic                 rel_valid_q, rel_valid_d;
  logic [NUM_WARPS-1:0] rel_mask_q, rel_mask_d;
  logic                 accept;

  logic [NUM_BARRIERS-1:0][XLEN-1:0]      gen_all;
  logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] rel_all, set_all;
  logic [NUM_BARRIERS-1:0]                cmpl_all;

  // A stalled warp cannot legally issue; anything it sends is discarded.
  assign accept = ctl_valid_i & bar_valid_i & ~stalled_q[ctl_wid_i];

  for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_slot
    warp_barrier_slot #(.NUM_WARPS(NUM_WARPS), .XLEN(XLEN), .NWW(NWW)) u_slot (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .cmd_i          (accept && (bar_id_i == NBW'(g))),
      .op_i           (bar_op_i),
      .wid_i          (ctl_wid_i),
      .size_m1_i      (bar_size_m1_i),
      .token_i        (bar_token_i),
      .gen_o          (gen_all[g]),
      .complete_o     (cmpl_all[g]),
      .release_mask_o (rel_all[g]),
      .stall_set_o    (set_all[g])
    );
  end

  always_comb begin
    rel_mask_d = '0;
    stalled_d  = stalled_q;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      rel_mask_d = rel_mask_d | rel_all[b];
      stalled_d  = stalled_d | set_all[b];
    end
    stalled_d   = stalled_d & ~rel_mask_d;
    rel_valid_d = |cmpl_all;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stalled_q   <= '0;
      rel_valid_q <= 1'b0;
      rel_mask_q  <= '0;
    end else begin
      stalled_q   <= stalled_d;
      rel_valid_q <= rel_valid_d;
      rel_mask_q  <= rel_mask_d;
    end
  end

  always @(posedge clk_i) begin
    if (!reset_i && ctl_valid_i && bar_valid_i)
      assert (!stalled_q[ctl_wid_i])
      else $warning("barrier command from stalled warp %0d dropped", ctl_wid_i);
  end

  assign arrive_token_o  = gen_all[barrier_id_rd_i];
  assign stalled_warps_o = stalled_q;
  assign release_valid_o = rel_valid_q;
  assign release_mask_o  = rel_mask_q;

endmodule

// File: tb/tb_warp_barrier_unit.sv
// Directed bench for warp_barrier_unit with a release-pulse scoreboard.
module tb_warp_barrier_unit;
  import VX_gpu_pkg::*;

`ifdef BARRIER_ASYNC_EN
  localparam bit ASYNC = 1'b1;
`else
  localparam bit ASYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ctl_valid, bar_valid;
  logic [1:0]  ctl_wid, bar_id, bar_size_m1, barrier_id_rd;
  bar_op_t     bar_op;
  logic [31:0] bar_token, arrive_token;
  logic [3:0]  stalled_warps, release_mask;
  logic        release_valid;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  warp_barrier_unit #(.NUM_WARPS(4), .NUM_BARRIERS(4), .XLEN(32)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .ctl_valid_i     (ctl_valid),
    .ctl_wid_i       (ctl_wid),
    .bar_valid_i     (bar_valid),
    .bar_op_i        (bar_op),
    .bar_id_i        (bar_id),
    .bar_size_m1_i   (bar_size_m1),
    .bar_token_i     (bar_token),
    .barrier_id_rd_i (barrier_id_rd),
    .arrive_token_o  (arrive_token),
    .stalled_warps_o (stalled_warps),
    .release_valid_o (release_valid),
    .release_mask_o  (release_mask)
  );

  // Monitor: every release pulse must match the oldest expected mask.
  always @(negedge clk) begin
    if (release_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL release_unexpected: got mask %b, required no release", release_mask);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (release_mask !== e) begin
          miscompares++;
          $display("FAIL release_mask: got %b, required %b", release_mask, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int w, input bar_op_t op, input int id, input int sm1,
                       input logic [31:0] tok);
    logic [31:0] wv, iv, sv;
    wv = w; iv = id; sv = sm1;
    ctl_valid = 1'b1; bar_valid = 1'b1; bar_op = op; bar_token = tok;
    ctl_wid = wv[1:0]; bar_id = iv[1:0]; bar_size_m1 = sv[1:0];
  endtask

  task automatic cmd(input int w, input bar_op_t op, input int id, input int sm1,
                     input logic [31:0] tok);
    drive(w, op, id, sm1, tok);
    tick();
    ctl_valid = 1'b0; bar_valid = 1'b0;
  endtask

  task automatic drained(input string nm);
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; ctl_valid = 1'b0; bar_valid = 1'b0; bar_op = BAR_SYNC;
    ctl_wid = '0; bar_id = '0; bar_size_m1 = '0; bar_token = '0; barrier_id_rd = '0;
    tick(); tick();
    chk("reset_stalled", stalled_warps, 0);
    chk("reset_rel_valid", release_valid, 0);
    chk("reset_rel_mask", release_mask, 0);
    chk("reset_token", arrive_token, 0);
    reset = 1'b0;
    tick();

    // Four-warp sync on barrier 1
    barrier_id_rd = 2'd1;
    cmd(0, BAR_SYNC, 1, 3, 0); chk("sync4_stall0", stalled_warps, 4'b0001);
    cmd(1, BAR_SYNC, 1, 3, 0); chk("sync4_stall1", stalled_warps, 4'b0011);
    cmd(2, BAR_SYNC, 1, 3, 0); chk("sync4_stall2", stalled_warps, 4'b0111);
    exp_q.push_back(4'b1111);
    cmd(3, BAR_SYNC, 1, 3, 0);
    chk("sync4_stall3", stalled_warps, 4'b0000);
    chk("sync4_rel_valid", release_valid, 1);
    drained("sync4_release_seen");
    chk("sync4_gen", arrive_token, ASYNC ? 1 : 0);
    tick();
    chk("pulse_one_cycle", release_valid, 0);

    // Size one: immediate completion, no stall
    exp_q.push_back(4'b0100);
    cmd(2, BAR_SYNC, 0, 0, 0);
    chk("size1_stall", stalled_warps, 0);
    drained("size1_release_seen");
    barrier_id_rd = 2'd0;
    chk("size1_gen", arrive_token, ASYNC ? 1 : 0);

    // Command from a stalled warp is dropped and does not count
    cmd(0, BAR_SYNC, 2, 1, 0); chk("drop_stall_a", stalled_warps, 4'b0001);
    cmd(0, BAR_SYNC, 2, 1, 0); chk("drop_stall_b", stalled_warps, 4'b0001);
    drained("drop_no_release");
    exp_q.push_back(4'b0011);
    cmd(1, BAR_SYNC, 2, 1, 0);
    chk("drop_stall_c", stalled_warps, 0);
    drained("drop_release_seen");

    // Mid-operation reset, with a completing arrival in the reset cycle
    cmd(0, BAR_SYNC, 0, 2, 0);
    cmd(1, BAR_SYNC, 0, 2, 0);
    chk("prerst_stall", stalled_warps, 4'b0011);
    reset = 1'b1;
    cmd(2, BAR_SYNC, 0, 2, 0);
    reset = 1'b0;
    chk("rst_stall", stalled_warps, 0);
    chk("rst_rel_valid", release_valid, 0);
    chk("rst_token", arrive_token, 0);
    cmd(0, BAR_SYNC, 0, 1, 0);
    chk("postrst_stall", stalled_warps, 4'b0001);
    drained("postrst_no_release");
    exp_q.push_back(4'b1001);
    cmd(3, BAR_SYNC, 0, 1, 0);
    chk("postrst_stall2", stalled_warps, 0);
    drained("postrst_release_seen");

`ifdef BARRIER_ASYNC_EN
    // Async arrive/wait on barrier 3
    barrier_id_rd = 2'd3;
    chk("async_tok0", arrive_token, 0);
    cmd(0, BAR_WAIT, 3, 0, 32'd0);
    chk("async_wait_stall", stalled_warps, 4'b0001);
    cmd(1, BAR_ARRIVE, 3, 1, 0);
    chk("async_arrive_nostall", stalled_warps, 4'b0001);
    exp_q.push_back(4'b0001);
    drive(2, BAR_ARRIVE, 3, 1, 0);
    #1 chk("async_same_cycle_tok", arrive_token, 0);
    tick(); ctl_valid = 1'b0; bar_valid = 1'b0;
    chk("async_tok1", arrive_token, 1);
    chk("async_released", stalled_warps, 0);
    drained("async_release_seen");
    cmd(0, BAR_WAIT, 3, 0, 32'd0);
    chk("async_stale_wait", stalled_warps, 0);

    // Generation wrap
    force dut.g_slot[3].u_slot.gen_q = 32'hFFFF_FFFF;
    #1 release dut.g_slot[3].u_slot.gen_q;
    chk("wrap_pre", arrive_token, 32'hFFFF_FFFF);
    cmd(1, BAR_ARRIVE, 3, 1, 0);
    exp_q.push_back(4'b0000);
    cmd(2, BAR_ARRIVE, 3, 1, 0);
    chk("wrap_tok", arrive_token, 0);
    drained("wrap_release_seen");
`else
    // Without async support, ARRIVE and WAIT behave as SYNC
    barrier_id_rd = 2'd3;
    cmd(1, BAR_ARRIVE, 3, 1, 0);
    chk("noasync_arrive_stall", stalled_warps, 4'b0010);
    exp_q.push_back(4'b0110);
    cmd(2, BAR_WAIT, 3, 1, 32'd5);
    chk("noasync_wait_stall", stalled_warps, 0);
    drained("noasync_release_seen");
    chk("noasync_token", arrive_token, 0);
`endif

    tick(); tick();
    drained("final_queue_empty");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
